// File: rtl/cmp_pkg.sv
// cmp_pkg: shared opcodes, sizes and slot state type for the compare arbiter
package cmp_pkg;
  localparam int N_REQ = 2;
  localparam int DEF_WIDTH = 32;
  localparam logic [2:0] OP_EQ = 3'd0;
  localparam logic [2:0] OP_NE = 3'd1;
  localparam logic [2:0] OP_LT = 3'd2;
  localparam logic [2:0] OP_GE = 3'd3;
  localparam logic [2:0] OP_LTU = 3'd4;
  localparam logic [2:0] OP_GEU = 3'd5;
  localparam logic [2:0] OP_GTZ = 3'd6;
  localparam logic [2:0] OP_LEZ = 3'd7;
  typedef enum logic {EMPTY, FULL} slot_e;
endpackage

// File: rtl/cmp_arbiter_if.sv
// cmp_arbiter_if: request/response bundle between the requesters and the arbiter
interface cmp_arbiter_if #(parameter int WIDTH = cmp_pkg::DEF_WIDTH);
  localparam int N = cmp_pkg::N_REQ;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [N*WIDTH-1:0] req_a;
  logic [N*WIDTH-1:0] req_b;
  logic [N*3-1:0] req_op;
  logic [N-1:0] rsp_valid;
  logic [N-1:0] rsp_ready;
  logic [N-1:0] rsp_taken;
  modport slave (
    input req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_taken
  );
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input req_ready, rsp_valid, rsp_taken
  );
endinterface

// File: rtl/cmp_core.sv
// cmp_core: combinational branch-style comparator, one result bit per opcode
module cmp_core import cmp_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             taken
);
  logic eq, lt, ltu, gtz;
  assign eq = a == b;
  assign lt = $signed(a) < $signed(b);
  assign ltu = a < b;
  assign gtz = ~a[WIDTH-1] & |a;
  always_comb
    case (op)
      OP_EQ:   taken = eq;
      OP_NE:   taken = ~eq;
      OP_LT:   taken = lt;
      OP_GE:   taken = ~lt;
      OP_LTU:  taken = ltu;
      OP_GEU:  taken = ~ltu;
      OP_GTZ:  taken = gtz;
      default: taken = ~gtz;
    endcase
endmodule

// File: rtl/cmp_arbiter.sv
// cmp_arbiter: two requesters share one comparator via round-robin grant;
// each requester owns a one-entry response slot with latency-1 results.
module cmp_arbiter import cmp_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic          clk,
  input logic          rst_n,
  cmp_arbiter_if.slave bus
);
  slot_e slot_q [N_REQ];
  slot_e slot_d [N_REQ];
  logic [N_REQ-1:0] full, elig, grant, pop, taken_q, taken_d;
  logic ptr_q, ptr_d, sel, result;
  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    assign full[i] = slot_q[i] == FULL;
    assign elig[i] = bus.req_valid[i] & (~full[i] | bus.rsp_ready[i]);
  end
  assign pop = full & bus.rsp_ready;
  // held in reset, nobody may handshake even though the slots already read empty
  assign grant = !rst_n ? '0 : &elig ? (ptr_q ? 2'b10 : 2'b01) : elig;
  assign sel = grant[1];
  assign ptr_d = |grant ? grant[0] : ptr_q;
  cmp_core #(.WIDTH(WIDTH)) u_core (
    .a(sel ? bus.req_a[WIDTH +: WIDTH] : bus.req_a[0 +: WIDTH]),
    .b(sel ? bus.req_b[WIDTH +: WIDTH] : bus.req_b[0 +: WIDTH]),
    .op(sel ? bus.req_op[3 +: 3] : bus.req_op[0 +: 3]),
    .taken(result)
  );
  always_comb
    for (int k = 0; k < N_REQ; k++) begin
      slot_d[k] = grant[k] ? FULL : pop[k] ? EMPTY : slot_q[k];
      taken_d[k] = grant[k] ? result : pop[k] ? 1'b0 : taken_q[k];
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot_q <= '{default: EMPTY};
      taken_q <= '0;
      ptr_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      taken_q <= taken_d;
      ptr_q <= ptr_d;
    end
  assign bus.req_ready = grant;
  assign bus.rsp_valid = full;
  assign bus.rsp_taken = taken_q;
endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: scenario tasks plus a per-requester result scoreboard
module tb_cmp_arbiter;
  import cmp_pkg::*;
  localparam int W = 32;
  localparam logic [W-1:0] TA [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'd5,
                                      32'd5, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1, 32'd0};
  localparam logic [W-1:0] TB [10] = '{32'd1, 32'd1, 32'd7, 32'd0, 32'd6,
                                      32'd6, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd5};
  localparam logic [2:0] TOP [10] = '{OP_LT, OP_LTU, OP_GTZ, OP_LEZ, OP_NE,
                                      OP_GE, OP_GE, OP_GEU, OP_GTZ, OP_LEZ};
  localparam bit TEXP [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  bit exp_q [2][$];
  cmp_arbiter_if #(.WIDTH(W)) bus();
  cmp_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic bit ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    case (op)
      OP_EQ:   return a == b;
      OP_NE:   return a != b;
      OP_LT:   return $signed(a) < $signed(b);
      OP_GE:   return $signed(a) >= $signed(b);
      OP_LTU:  return a < b;
      OP_GEU:  return a >= b;
      OP_GTZ:  return !a[W-1] && a != 0;
      default: return a[W-1] || a == 0;
    endcase
  endfunction

  // scoreboard: pop/compare the pending result, then push any new handshake
  always @(negedge clk)
    if (rst_n) begin
      checks++;
      if ($countones(bus.req_ready) > 1) begin
        errors++;
        $display("FAIL onehot req_ready=%b", bus.req_ready);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (bus.rsp_valid[i] !== (exp_q[i].size() != 0)) begin
          errors++;
          $display("FAIL sb_valid%0d got=%b exp=%0d", i, bus.rsp_valid[i], exp_q[i].size() != 0);
        end
        if (exp_q[i].size() != 0) begin
          checks++;
          if (bus.rsp_taken[i] !== exp_q[i][0]) begin
            errors++;
            $display("FAIL sb_taken%0d got=%b exp=%b", i, bus.rsp_taken[i], exp_q[i][0]);
          end
          if (bus.rsp_ready[i]) void'(exp_q[i].pop_front());
        end
        if (bus.req_valid[i] && bus.req_ready[i])
          exp_q[i].push_back(ref_cmp(bus.req_a[i*W +: W], bus.req_b[i*W +: W], bus.req_op[i*3 +: 3]));
      end
    end

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_op[i*3 +: 3] = op;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    exp_q[0].delete();
    exp_q[1].delete();
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.rsp_ready = '0;
    bus.req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b00 || bus.rsp_taken !== 2'b00) begin
      errors++;
      $display("FAIL reset_rsp valid=%b taken=%b exp=00/00", bus.rsp_valid, bus.rsp_taken);
    end
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got=%b exp=00", bus.req_ready);
    end
    next();
    bus.req_valid = '0;
    rst_n = 1'b1;
    next();
  endtask

  task automatic test_basic();
    set_req(0, 32'd5, 32'd5, OP_EQ);
    bus.req_valid = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL basic_grant got=%b exp=01", bus.req_ready);
    end
    next();
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_taken[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_rsp valid=%b taken0=%b exp=01/1", bus.rsp_valid, bus.rsp_taken[0]);
    end
    next();
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    next();
    bus.rsp_ready = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL basic_pop got=%b exp=00", bus.rsp_valid);
    end
    next();
  endtask

  task automatic test_alternate();
    logic [1:0] prev, exp;
    logic [W-1:0] ra;
    do_reset();
    prev = 2'b00;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 2; i++) begin
        ra = $urandom;
        set_req(i, ra, $urandom_range(0, 1) != 0 ? ra : W'($urandom), 3'($urandom_range(0, 7)));
      end
      exp = k % 2 != 0 ? 2'b10 : 2'b01;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== exp) begin
        errors++;
        $display("FAIL alt_grant k=%0d got=%b exp=%b", k, bus.req_ready, exp);
      end
      checks++;
      if (bus.rsp_valid !== prev) begin
        errors++;
        $display("FAIL alt_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, prev);
      end
      prev = exp;
      next();
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
    next();
  endtask

  task automatic test_signed();
    bus.rsp_ready = 2'b01;
    for (int k = 0; k < 10; k++) begin
      set_req(0, TA[k], TB[k], TOP[k]);
      bus.req_valid = 2'b01;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b01) begin
        errors++;
        $display("FAIL b2b_grant k=%0d got=%b exp=01", k, bus.req_ready);
      end
      if (k > 0) begin
        checks++;
        if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_taken[0] !== TEXP[k-1]) begin
          errors++;
          $display("FAIL op_result k=%0d valid=%b taken=%b exp=1/%b", k - 1, bus.rsp_valid[0], bus.rsp_taken[0], TEXP[k-1]);
        end
      end
      next();
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.rsp_taken[0] !== TEXP[9]) begin
      errors++;
      $display("FAIL op_result k=9 got=%b exp=%b", bus.rsp_taken[0], TEXP[9]);
    end
    next();
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_stall();
    set_req(0, 32'd3, 32'd3, OP_EQ);
    bus.req_valid = 2'b01;
    @(negedge clk);
    next();
    set_req(0, 32'd1, 32'd2, OP_EQ);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      set_req(1, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b10) begin
        errors++;
        $display("FAIL stall_grant k=%0d got=%b exp=10", k, bus.req_ready);
      end
      checks++;
      if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_taken[0] !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold k=%0d valid0=%b taken0=%b exp=1/1", k, bus.rsp_valid[0], bus.rsp_taken[0]);
      end
      next();
    end
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL stall_release got=%b exp=01", bus.req_ready);
    end
    next();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b11 || bus.rsp_taken[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_newres valid=%b taken0=%b exp=11/0", bus.rsp_valid, bus.rsp_taken[0]);
    end
    next();
  endtask

  task automatic test_withdraw();
    logic [1:0] vseq [5] = '{2'b11, 2'b01, 2'b11, 2'b00, 2'b11};
    logic [1:0] gseq [5] = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b01};
    do_reset();
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = vseq[k];
      @(negedge clk);
      checks++;
      if (bus.req_ready !== gseq[k]) begin
        errors++;
        $display("FAIL withdraw_grant k=%0d got=%b exp=%b", k, bus.req_ready, gseq[k]);
      end
      next();
    end
    bus.req_valid = 2'b00;
    @(negedge clk);
    next();
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 2'b00;
    bus.req_valid = 2'b11;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL fill_grant1 got=%b exp=10", bus.req_ready);
    end
    next();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL fill_grant0 got=%b exp=01", bus.req_ready);
    end
    next();
    bus.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 2'b11) begin
      errors++;
      $display("FAIL fill_valid got=%b exp=11", bus.rsp_valid);
    end
    #2;
    bus.req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 2'b00 || bus.rsp_taken !== 2'b00) begin
      errors++;
      $display("FAIL async_clear valid=%b taken=%b exp=00/00", bus.rsp_valid, bus.rsp_taken);
    end
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL async_ready got=%b exp=00", bus.req_ready);
    end
    bus.req_valid = 2'b00;
    exp_q[0].delete();
    exp_q[1].delete();
    #1 rst_n = 1'b1;
    next();
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_grant got=%b exp=01", bus.req_ready);
    end
    next();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL post_reset_next got=%b exp=10", bus.req_ready);
    end
    next();
    bus.req_valid = 2'b00;
    @(negedge clk);
    next();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_signed();
    test_stall();
    test_withdraw();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 2, per-requester request valid (bit i = requester i).
REQ-005 The block SHALL have port req_ready, output, 2, per-requester request accepted this cycle.
REQ-006 The block SHALL have port req_a, input, 2*WIDTH, operand A; requester i in bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port req_b, input, 2*WIDTH, operand B, same packing as req_a.
REQ-008 The block SHALL have port req_op, input, 6, 3-bit compare opcode per requester; requester i in bits [i*3 +: 3].
REQ-009 The block SHALL have port rsp_valid, output, 2, per-requester response valid.
REQ-010 The block SHALL have port rsp_ready, input, 2, per-requester response consumed.
REQ-011 The block SHALL have port rsp_taken, output, 2, per-requester 1-bit compare result.

Function
REQ-012 Opcodes SHALL be: 0 EQ a==b; 1 NE a!=b; 2 LT signed a<b; 3 GE signed a>=b; 4 LTU unsigned a<b; 5 GEU unsigned a>=b; 6 GTZ signed a>0; 7 LEZ signed a<=0 (b ignored for 6 and 7).
REQ-013 A single shared cmp_core instance SHALL evaluate at most one request per cycle.
REQ-014 Requester i SHALL be eligible when req_valid[i]=1 and its response slot is empty, or full with rsp_ready[i]=1 in the same cycle.
REQ-015 At most one req_ready bit SHALL be high per cycle; it SHALL go to the single eligible requester, or, when both are eligible, to the requester named by the round-robin pointer.
REQ-016 The round-robin pointer SHALL point to the other requester after each grant and SHALL hold when there is no grant.
REQ-017 req_ready SHALL be combinational from req_valid, rsp_ready, the slot state and the pointer; it SHALL not depend on req_a, req_b or req_op.
REQ-018 The handshake SHALL occur on req_valid[i] & req_ready[i]; in the following cycle rsp_valid[i]=1 and rsp_taken[i] SHALL hold the result from the operands sampled at the handshake edge (latency 1).
REQ-019 rsp_valid[i] and rsp_taken[i] SHALL stay stable until the cycle with rsp_ready[i]=1, and SHALL clear on that edge unless a new grant to i happens in the same cycle.
REQ-020 A same-cycle pop and new grant to the same requester SHALL keep rsp_valid[i]=1 and load the new result (back-to-back throughput of 1 per requester).
REQ-021 rsp_ready[i] asserted while rsp_valid[i]=0 SHALL be ignored.
REQ-022 A requester that deasserts req_valid before it is granted SHALL lose nothing, and the pointer SHALL not change.
REQ-023 Each response slot SHALL be a two-state FSM, EMPTY to FULL on grant, FULL to EMPTY on pop without grant, FULL to FULL on pop with grant or on no pop.

Reset
REQ-024 On rst_n=0 the block SHALL immediately clear rsp_valid to 2'b00, rsp_taken to 2'b00, both slots to EMPTY and the pointer to requester 0, regardless of the clock.
REQ-025 req_ready SHALL be 2'b00 while rst_n=0.
REQ-026 A request or response in flight at reset SHALL be discarded without being returned.

Structure
REQ-027 Opcode localparams (OP_EQ..OP_LEZ), the requester count 2 and the default WIDTH SHALL live in a shared package cmp_pkg.
REQ-028 The comparison SHALL be in a combinational sub-module cmp_core with inputs a, b and op and output taken; the arbitration, pointer and slots SHALL stay in cmp_arbiter.

Verification
REQ-029 Reset, then req0 EQ a=5 b=5 -> req_ready=01 that cycle; next cycle rsp_valid=01, rsp_taken[0]=1.
REQ-030 Both requesters valid every cycle, rsp_ready=11 -> grants alternate 0,1,0,1 starting with 0; each rsp_valid pulses 1 cycle after its grant.
REQ-031 Signed versus unsigned with a=32'hFFFF_FFFF, b=1 -> LT gives 1, LTU gives 0; GTZ with a=0 gives 0; LEZ with a=32'h8000_0000 gives 1.
REQ-032 rsp_ready[0]=0 held for 5 cycles with req0 valid -> req_ready[0] stays 0 and rsp_taken[0] stays stable; requester 1 is granted every cycle meanwhile.
REQ-033 rst_n pulsed low mid-cycle while rsp_valid=11 -> rsp_valid=00 immediately with no clock edge; the first grant after release goes to requester 0.
